// File: rtl/uart_rx_line_collect.sv
// uart_rx_line_collect
// Assembles received UART bytes into an ASCII command line. A working buffer
// collects the next line while the published line waits for its ack.
// Characters are stored MSB-first: char 0 occupies the top byte, and unused
// positions hold 0x20.

module uart_rx_line_collect #(
    parameter int MAX_CHARS = 32
) (
    input  logic                           i_clk_20mhz,
    input  logic                           i_rst_20mhz,
    input  logic [7:0]                     i_rx_data,
    input  logic                           i_rx_valid,
    output logic [MAX_CHARS*8-1:0]         o_line_ascii,
    output logic [$clog2(MAX_CHARS+1)-1:0] o_line_len,
    output logic                           o_line_valid,
    input  logic                           i_line_ack,
    output logic                           o_err_overflow,
    output logic                           o_err_overrun
);

    localparam int CW = $clog2(MAX_CHARS + 1);
    localparam int LW = MAX_CHARS * 8;
    localparam logic [LW-1:0] BLANK = {MAX_CHARS{8'h20}};
    localparam logic [CW-1:0] FULL  = CW'(MAX_CHARS);

    typedef enum logic [0:0] {
        ST_RXLINE_COLL = 1'b0,
        ST_RXLINE_SKIP = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [LW-1:0]   r_work;
    logic [LW-1:0]   w_work_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic [LW-1:0]   r_line;
    logic [LW-1:0]   w_line_nxt;
    logic [CW-1:0]   r_len;
    logic [CW-1:0]   w_len_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            r_ovf;
    logic            w_ovf_nxt;
    logic            r_ovr;
    logic            w_ovr_nxt;

    logic            w_is_term;
    logic            w_is_bs;
    logic            w_is_print;
    logic            w_pub_ok;

    assign w_is_term  = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
    assign w_is_bs    = (i_rx_data == 8'h08) || (i_rx_data == 8'h7F);
    assign w_is_print = (i_rx_data >= 8'h20) && (i_rx_data <= 8'h7E);
    // An ack in the same cycle frees the output slot for the new line.
    assign w_pub_ok   = !r_valid || i_line_ack;

    // Register all state; async reset restores the idle, blank condition.
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            r_state <= ST_RXLINE_COLL;
            r_work  <= BLANK;
            r_count <= '0;
            r_line  <= BLANK;
            r_len   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_count <= w_count_nxt;
            r_line  <= w_line_nxt;
            r_len   <= w_len_nxt;
            r_valid <= w_valid_nxt;
            r_ovf   <= w_ovf_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    // Next-state: byte classification, line editing, publish and handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_count_nxt = r_count;
        w_line_nxt  = r_line;
        w_len_nxt   = r_len;
        w_valid_nxt = r_valid;
        w_ovf_nxt   = 1'b0;
        w_ovr_nxt   = 1'b0;

        if (r_valid && i_line_ack) begin
            w_valid_nxt = 1'b0;
        end

        if (i_rx_valid) begin
            case (r_state)
                ST_RXLINE_COLL: begin
                    if (w_is_print) begin
                        if (r_count < FULL) begin
                            for (int unsigned i = 0; i < MAX_CHARS; i++) begin
                                if (CW'(i) == r_count) begin
                                    w_work_nxt[(MAX_CHARS-1-i)*8 +: 8] = i_rx_data;
                                end
                            end
                            w_count_nxt = r_count + 1'b1;
                        end else begin
                            w_ovf_nxt   = 1'b1;
                            w_work_nxt  = BLANK;
                            w_count_nxt = '0;
                            w_state_nxt = ST_RXLINE_SKIP;
                        end
                    end else if (w_is_bs) begin
                        if (r_count != '0) begin
                            for (int unsigned i = 0; i < MAX_CHARS; i++) begin
                                if (CW'(i + 1) == r_count) begin
                                    w_work_nxt[(MAX_CHARS-1-i)*8 +: 8] = 8'h20;
                                end
                            end
                            w_count_nxt = r_count - 1'b1;
                        end
                    end else if (w_is_term) begin
                        if (r_count != '0) begin
                            if (w_pub_ok) begin
                                w_line_nxt  = r_work;
                                w_len_nxt   = r_count;
                                w_valid_nxt = 1'b1;
                            end else begin
                                w_ovr_nxt = 1'b1;
                            end
                            w_work_nxt  = BLANK;
                            w_count_nxt = '0;
                        end
                    end
                end
                ST_RXLINE_SKIP: begin
                    // Working buffer was already cleared on entry.
                    if (w_is_term) begin
                        w_state_nxt = ST_RXLINE_COLL;
                    end
                end
                default: begin
                    w_state_nxt = ST_RXLINE_COLL;
                end
            endcase
        end
    end

    assign o_line_ascii   = r_line;
    assign o_line_len     = r_len;
    assign o_line_valid   = r_valid;
    assign o_err_overflow = r_ovf;
    assign o_err_overrun  = r_ovr;

endmodule
